// File: rtl/huffman_cfg_loader_if.sv
// Port bundle between a Huffman table source and the configuration loader.
// The loader takes the slave side; the source/encoder side takes the master side.
interface huffman_cfg_loader_if #(
    parameter int unsigned W = 8
);
    logic         start;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic [W-1:0] s_code;
    logic [W-1:0] s_width;
    logic         s_last;
    logic [W-1:0] d_conf;
    logic [W-1:0] h_conf;
    logic [W-1:0] w_conf;
    logic         en_conf;
    logic         new_conf;
    logic         run_en;
    logic         busy;
    logic         done;
    logic         err;
    logic [1:0]   err_code;
    logic [8:0]   entry_cnt;

    modport master (
        output start, s_valid, s_data, s_code, s_width, s_last,
        input  s_ready, d_conf, h_conf, w_conf, en_conf, new_conf,
        input  run_en, busy, done, err, err_code, entry_cnt
    );

    modport slave (
        input  start, s_valid, s_data, s_code, s_width, s_last,
        output s_ready, d_conf, h_conf, w_conf, en_conf, new_conf,
        output run_en, busy, done, err, err_code, entry_cnt
    );
endinterface

// File: rtl/huffman_cfg_loader.sv
// Loads a Huffman code table into the encoder, validating every entry and
// checking the Kraft sum is exactly complete before letting the encoder run.
module huffman_cfg_loader #(
    parameter int unsigned W = 8
) (
    input  logic                clk,
    input  logic                rst,
    huffman_cfg_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, CHECK, RUN, ERR} state_e;

    localparam logic [9:0] KRAFT_FULL = 10'd256;

    state_e       state_q, state_d;
    logic [9:0]   ksum_q, ksum_d;
    logic [8:0]   entry_cnt_q, entry_cnt_d;
    logic [W-1:0] d_conf_q, d_conf_d;
    logic [W-1:0] h_conf_q, h_conf_d;
    logic [W-1:0] w_conf_q, w_conf_d;
    logic         en_conf_q, en_conf_d;
    logic [1:0]   err_code_q, err_code_d;

    logic         xfer, width_ok, code_ok, entry_ok, overflow, accept, restart;
    logic [9:0]   wt, ksum_sum;

    always_comb begin
        xfer     = (state_q == LOAD) && bus.s_valid;
        width_ok = (bus.s_width >= W'(2)) && (bus.s_width <= W'(8));
        code_ok  = {1'b0, bus.s_code} < ((W+1)'(1) << bus.s_width[3:0]);
        entry_ok = width_ok && code_ok;
        // Weight is only meaningful once width_ok holds (shift amount 0..6).
        wt       = 10'd1 << (4'd8 - bus.s_width[3:0]);
        ksum_sum = ksum_q + wt;
        overflow = ksum_sum > KRAFT_FULL;
        accept   = xfer && entry_ok && !overflow;
        restart  = bus.start && (state_q inside {IDLE, RUN, ERR});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start) state_d = CLEAR;
            CLEAR: state_d = LOAD;
            LOAD: begin
                if (xfer) begin
                    if (!entry_ok || overflow) state_d = ERR;
                    else if (bus.s_last)       state_d = CHECK;
                end
            end
            CHECK: state_d = (ksum_q == KRAFT_FULL) ? RUN : ERR;
            RUN:   if (bus.start) state_d = CLEAR;
            ERR:   if (bus.start) state_d = CLEAR;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.s_ready  = (state_q == LOAD);
        bus.new_conf = (state_q == CLEAR);
        bus.busy     = (state_q == CLEAR) || (state_q == LOAD) || (state_q == CHECK);
        bus.run_en   = (state_q == RUN);
        bus.err      = (state_q == ERR);
        bus.done     = (state_q == CHECK) && (ksum_q == KRAFT_FULL);
    end

    always_comb begin
        ksum_d      = ksum_q;
        entry_cnt_d = entry_cnt_q;
        d_conf_d    = d_conf_q;
        h_conf_d    = h_conf_q;
        w_conf_d    = w_conf_q;
        en_conf_d   = 1'b0;
        err_code_d  = err_code_q;
        // Status is cleared on the start edge so CLEAR already shows a clean slate.
        if (restart) begin
            ksum_d      = '0;
            entry_cnt_d = '0;
            err_code_d  = '0;
        end
        if (accept) begin
            d_conf_d    = bus.s_data;
            h_conf_d    = bus.s_code;
            w_conf_d    = bus.s_width;
            en_conf_d   = 1'b1;
            ksum_d      = ksum_sum;
            entry_cnt_d = entry_cnt_q + 9'd1;
        end
        if (xfer && !entry_ok)           err_code_d = 2'b01;
        else if (xfer && overflow)       err_code_d = 2'b10;
        if ((state_q == CHECK) && (ksum_q != KRAFT_FULL)) err_code_d = 2'b11;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ksum_q      <= '0;
            entry_cnt_q <= '0;
            d_conf_q    <= '0;
            h_conf_q    <= '0;
            w_conf_q    <= '0;
            en_conf_q   <= 1'b0;
            err_code_q  <= '0;
        end else begin
            ksum_q      <= ksum_d;
            entry_cnt_q <= entry_cnt_d;
            d_conf_q    <= d_conf_d;
            h_conf_q    <= h_conf_d;
            w_conf_q    <= w_conf_d;
            en_conf_q   <= en_conf_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.d_conf    = d_conf_q;
    assign bus.h_conf    = h_conf_q;
    assign bus.w_conf    = w_conf_q;
    assign bus.en_conf   = en_conf_q;
    assign bus.err_code  = err_code_q;
    assign bus.entry_cnt = entry_cnt_q;
endmodule

// File: tb/tb_huffman_cfg_loader.sv
// Bench for huffman_cfg_loader: directed scenarios plus random Kraft tables,
// each checked against a table-level model of the load rules.
module tb_huffman_cfg_loader;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] code;
        logic [7:0] width;
        logic       last;
    } entry_t;

    entry_t     tbl[$];
    logic [7:0] exp_d, exp_h, exp_w;

    huffman_cfg_loader_if #(.W(W)) bus ();
    huffman_cfg_loader #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within its time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int unsigned d, input int unsigned c, input int unsigned w, input bit l);
        entry_t e;
        e.data = d[7:0]; e.code = c[7:0]; e.width = w[7:0]; e.last = l;
        tbl.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {bus.s_ready, bus.busy, bus.en_conf, bus.new_conf,
                                bus.run_en, bus.done, bus.err}, 0);
        check({tag, "_err_code"}, bus.err_code, 0);
        check({tag, "_cnt"}, bus.entry_cnt, 0);
        check({tag, "_conf"}, {bus.d_conf, bus.h_conf, bus.w_conf}, 0);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("clear_new_conf", bus.new_conf, 1);
        check("clear_busy", bus.busy, 1);
        check("clear_run_en", bus.run_en, 0);
        check("clear_status", {bus.err, bus.err_code}, 0);
        check("clear_cnt", bus.entry_cnt, 0);
        check("clear_s_ready", bus.s_ready, 0);
        tick();
        check("load_new_conf", bus.new_conf, 0);
        check("load_s_ready", bus.s_ready, 1);
    endtask

    // Drives tbl into the loader and predicts every outcome from the table rules.
    task automatic run_table(input int unsigned max_gap);
        int unsigned ksum, cnt, wt, gap;
        bit ok;
        ksum = 0;
        cnt  = 0;
        foreach (tbl[i]) begin
            gap = $urandom_range(max_gap, 0);
            for (int g = 0; g < int'(gap); g++) begin
                bus.s_valid = 1'b0;
                bus.s_data  = $urandom;
                bus.s_code  = $urandom;
                bus.s_width = $urandom;
                bus.s_last  = $urandom;
                bus.start   = $urandom_range(1, 0);
                tick();
                bus.start = 1'b0;
                check("gap_no_strobe", bus.en_conf, 0);
                check("gap_ready", bus.s_ready, 1);
                check("gap_start_ignored", bus.new_conf, 0);
                check("gap_hold", {bus.d_conf, bus.h_conf, bus.w_conf}, {exp_d, exp_h, exp_w});
            end
            bus.s_valid = 1'b1;
            bus.s_data  = tbl[i].data;
            bus.s_code  = tbl[i].code;
            bus.s_width = tbl[i].width;
            bus.s_last  = tbl[i].last;
            tick();
            bus.s_valid = 1'b0;
            ok = (tbl[i].width >= 2) && (tbl[i].width <= 8) &&
                 (int'(tbl[i].code) < (1 << tbl[i].width));
            if (!ok) begin
                check("bad_err", bus.err, 1);
                check("bad_err_code", bus.err_code, 1);
                check("bad_no_strobe", bus.en_conf, 0);
                check("bad_ready_drop", bus.s_ready, 0);
                check("bad_hold", {bus.d_conf, bus.h_conf, bus.w_conf}, {exp_d, exp_h, exp_w});
                return;
            end
            wt = 1 << (8 - tbl[i].width);
            if (ksum + wt > 256) begin
                check("ovf_err", bus.err, 1);
                check("ovf_err_code", bus.err_code, 2);
                check("ovf_no_strobe", bus.en_conf, 0);
                check("ovf_ready_drop", bus.s_ready, 0);
                check("ovf_cnt", bus.entry_cnt, cnt);
                return;
            end
            ksum += wt;
            cnt++;
            exp_d = tbl[i].data;
            exp_h = tbl[i].code;
            exp_w = tbl[i].width;
            check("strobe", bus.en_conf, 1);
            check("conf", {bus.d_conf, bus.h_conf, bus.w_conf}, {exp_d, exp_h, exp_w});
            check("cnt", bus.entry_cnt, cnt);
            if (tbl[i].last) begin
                check("check_ready_drop", bus.s_ready, 0);
                check("check_busy", bus.busy, 1);
                check("done_pulse", bus.done, ksum == 256);
                tick();
                check("after_check_strobe", bus.en_conf, 0);
                check("after_check_done", bus.done, 0);
                check("after_check_busy", bus.busy, 0);
                if (ksum == 256) begin
                    check("run_en", bus.run_en, 1);
                    check("run_no_err", {bus.err, bus.err_code}, 0);
                end else begin
                    check("kraft_err", bus.err, 1);
                    check("kraft_err_code", bus.err_code, 3);
                    check("kraft_run_en", bus.run_en, 0);
                end
                return;
            end
        end
    endtask

    task automatic gen_random_table();
        int unsigned ws[$];
        int unsigned k;
        entry_t e;
        tbl.delete();
        ws = '{2, 2, 2, 2};
        repeat ($urandom_range(6, 0)) begin
            k = $urandom_range(ws.size() - 1, 0);
            if (ws[k] < 8) begin
                ws[k] = ws[k] + 1;
                ws.insert(k, ws[k]);
            end
        end
        foreach (ws[i]) add($urandom, $urandom_range((1 << ws[i]) - 1, 0), ws[i], 1'b0);
        k = $urandom_range(tbl.size() - 1, 0);
        case ($urandom_range(5, 0))
            0: tbl[k].width = ($urandom_range(1, 0) != 0) ? 8'd9 : 8'd1;
            1: begin
                if (tbl[k].width < 8) tbl[k].code = 8'((1 << tbl[k].width) + $urandom_range(3, 0));
                else                  tbl[k].width = 8'd1;
            end
            2: if (tbl.size() > 1) e = tbl.pop_back();
            3: add($urandom, 0, $urandom_range(8, 2), 1'b0);
            default: ;
        endcase
        tbl[tbl.size() - 1].last = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
        bus.s_data = '0; bus.s_code = '0; bus.s_width = '0;
        exp_d = '0; exp_h = '0; exp_w = '0;
        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b0;
        bus.s_valid = 1'b1;
        repeat (3) begin
            tick();
            check("idle_no_ready", {bus.s_ready, bus.busy, bus.new_conf, bus.run_en}, 0);
        end
        bus.s_valid = 1'b0;

        tbl.delete();
        add(8'h41, 0, 2, 0); add(8'h42, 1, 2, 0); add(8'h43, 2, 2, 0); add(8'h44, 3, 2, 1);
        do_start();
        run_table(0);
        check("full_cnt", bus.entry_cnt, 4);
        repeat ($urandom_range(4, 1)) begin
            tick();
            check("run_hold", {bus.run_en, bus.busy, bus.en_conf, bus.new_conf}, 4'b1000);
        end

        tbl.delete(); add(8'h10, 0, 9, 1);
        do_start();
        run_table(0);
        tbl.delete(); add(8'h11, 1, 2, 0); add(8'h12, 4, 2, 1);
        do_start();
        run_table(0);

        tbl.delete();
        for (int i = 0; i < 5; i++) add(8'h20 + i, i % 4, 2, 0);
        do_start();
        run_table(0);
        check("five_cnt", bus.entry_cnt, 4);

        tbl.delete(); add(8'h30, 0, 2, 0); add(8'h31, 1, 2, 0); add(8'h32, 2, 2, 1);
        do_start();
        run_table(1);
        check("partial_cnt", bus.entry_cnt, 3);

        repeat (40) begin
            do_start();
            gen_random_table();
            run_table(2);
        end

        tbl.delete(); add(8'h51, 0, 2, 0); add(8'h52, 1, 2, 0);
        do_start();
        run_table(0);
        check("pre_reset_cnt", bus.entry_cnt, 2);
        bus.s_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        exp_d = '0; exp_h = '0; exp_w = '0;
        check_all_zero("midload_reset");
        #3 rst = 1'b0;
        bus.s_valid = 1'b0;
        repeat (4) begin
            tick();
            check("post_reset_idle", {bus.new_conf, bus.s_ready, bus.busy, bus.en_conf}, 0);
        end
        check("post_reset_cnt", bus.entry_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
